// File: rtl/alu_issue_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter_pkg
//   Shared types and defaults for the VALU issue arbiter:
//   - arb_state_e : arbiter FSM encoding (IDLE / ISSUE / BUSY)
//   - DEF_*       : default parameter values for the top level
//   - cnt_width() : width of a counter that must hold 0..limit
// ---------------------------------------------------------------------------
package alu_issue_arbiter_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ID_W           = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    BUSY  = 2'b10
  } arb_state_e;

  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter_if
//   Bundles the requester-side and ALU-FSM-side handshake of the arbiter.
//   Signals:
//     req, req_mask        requester level requests / eligibility mask
//     grant, done          one-hot single-cycle pulses back to requesters
//     owner_id, busy       current/last owner and op-in-flight flag
//     alu_ready, alu_wb    from the ALU FSM (idle, writeback pulse)
//     alu_select           start pulse to the ALU FSM
//     err_timeout          sticky watchdog error
//   Modports:
//     master : the arbiter (drives grant/done/owner_id/busy/alu_select/err)
//     slave  : the surrounding logic (drives req/req_mask/alu_ready/alu_wb)
// ---------------------------------------------------------------------------
interface alu_issue_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_mask;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic [ID_W-1:0]    owner_id;
  logic               busy;
  logic               alu_ready;
  logic               alu_select;
  logic               alu_wb;
  logic               err_timeout;

  modport master (
    input  req, req_mask, alu_ready, alu_wb,
    output grant, done, owner_id, busy, alu_select, err_timeout
  );

  modport slave (
    output req, req_mask, alu_ready, alu_wb,
    input  grant, done, owner_id, busy, alu_select, err_timeout
  );

endinterface

// File: rtl/alu_issue_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter_rr_pick
//   Combinational round-robin picker. Searches the eligible vector upward
//   starting at i_rr_ptr, wrapping from NUM_REQ-1 back to 0, and returns the
//   index of the first set bit.
//   Ports:
//     i_elig    [NUM_REQ]  eligible requesters (req & req_mask)
//     i_rr_ptr  [ID_W]     highest-priority index this round (< NUM_REQ)
//     o_winner  [ID_W]     index of the selected requester
//     o_valid   [1]        at least one requester eligible
// ---------------------------------------------------------------------------
module alu_issue_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_valid
);

  // w_rot_idx[k] is the requester index that has the k-th highest priority.
  logic [ID_W-1:0]    w_rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] w_hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [ID_W:0] w_sum;
    assign w_sum          = {1'b0, i_rr_ptr} + (ID_W+1)'(gi);
    // Wrap without a modulo: rr_ptr < NUM_REQ, so one subtraction suffices.
    assign w_rot_idx[gi]  = (w_sum >= (ID_W+1)'(NUM_REQ))
                            ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                            : ID_W'(w_sum);
    assign w_hit[gi]      = i_elig[w_rot_idx[gi]];
  end

  // Scan from lowest priority to highest so the closest hit wins.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_winner = w_rot_idx[k];
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter
//   Round-robin arbiter sharing one VALU pipeline between NUM_REQ issue
//   requesters. Picks a winner among eligible requests while the ALU FSM is
//   ready, pulses grant + alu_select, holds ownership until alu_wb, then
//   pulses done to the owner and rotates priority past it.
//
//   Ports:
//     clk   in   clock, all state changes on the rising edge
//     rst   in   synchronous active-high reset
//     bus   alu_issue_arbiter_if.master (see interface header for signals)
//
//   Optional feature (macro ALU_ARB_WATCHDOG_EN):
//     BUSY watchdog. After TIMEOUT_CYCLES BUSY cycles without alu_wb the op
//     is abandoned: err_timeout sets (sticky until rst), busy drops, no done
//     pulse, and priority moves past the owner. Without the macro BUSY waits
//     forever and err_timeout is tied low.
//
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ID_W           = DEF_ID_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_arbiter_if.master bus
);

  arb_state_e         r_state, w_state_next;
  logic [NUM_REQ-1:0] r_grant, w_grant_next;
  logic [NUM_REQ-1:0] r_done, w_done_next;
  logic [ID_W-1:0]    r_owner_id, w_owner_id_next;
  logic [ID_W-1:0]    r_rr_ptr, w_rr_ptr_next;
  logic               r_busy, w_busy_next;
  logic               r_alu_select, w_alu_select_next;

  logic [NUM_REQ-1:0] w_elig;
  logic [ID_W-1:0]    w_winner;
  logic               w_winner_valid;
  logic [NUM_REQ-1:0] w_winner_oh;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic [ID_W-1:0]    w_owner_plus1;
  logic               w_timeout;
  logic               w_err_timeout;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  assign w_elig = bus.req & bus.req_mask;

  alu_issue_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_elig   (w_elig),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_valid  (w_winner_valid)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign w_winner_oh[gi] = (w_winner   == ID_W'(gi));
    assign w_owner_oh[gi]  = (r_owner_id == ID_W'(gi));
  end

  // Next priority start: one past the owner, wrapping at NUM_REQ-1.
  assign w_owner_plus1 = (r_owner_id == ID_W'(NUM_REQ - 1))
                         ? '0 : r_owner_id + ID_W'(1);

  // -------------------------------------------------------------------------
  // Optional BUSY watchdog
  // -------------------------------------------------------------------------
`ifdef ALU_ARB_WATCHDOG_EN
  localparam int WD_CNT_W = cnt_width(TIMEOUT_CYCLES);

  logic [WD_CNT_W-1:0] r_wd_cnt;
  logic                r_err_timeout;

  // Fires on the TIMEOUT_CYCLES-th BUSY cycle; a same-cycle alu_wb wins.
  assign w_timeout = (r_state == BUSY) && !bus.alu_wb &&
                     (r_wd_cnt == WD_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      // Counter clears on the ISSUE->BUSY transition and counts in BUSY.
      if (r_state == ISSUE) begin
        r_wd_cnt <= '0;
      end else if (r_state == BUSY) begin
        r_wd_cnt <= r_wd_cnt + WD_CNT_W'(1);
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign w_err_timeout = r_err_timeout;
`else
  assign w_timeout     = 1'b0;
  assign w_err_timeout = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = '0;
    w_done_next       = '0;
    w_alu_select_next = 1'b0;
    w_busy_next       = r_busy;
    w_owner_id_next   = r_owner_id;
    w_rr_ptr_next     = r_rr_ptr;

    case (r_state)
      IDLE: begin
        w_busy_next = 1'b0;
        if (bus.alu_ready && w_winner_valid) begin
          w_owner_id_next   = w_winner;
          w_grant_next      = w_winner_oh;
          w_alu_select_next = 1'b1;
          w_busy_next       = 1'b1;
          w_state_next      = ISSUE;
        end
      end

      ISSUE: begin
        // alu_wb here is stray (outside BUSY) and deliberately ignored.
        w_busy_next  = 1'b1;
        w_state_next = BUSY;
      end

      BUSY: begin
        w_busy_next = 1'b1;
        if (bus.alu_wb) begin
          w_done_next   = w_owner_oh;
          w_busy_next   = 1'b0;
          w_rr_ptr_next = w_owner_plus1;
          w_state_next  = IDLE;
        end else if (w_timeout) begin
          // Abandon the op: no done pulse, but still rotate past the owner.
          w_busy_next   = 1'b0;
          w_rr_ptr_next = w_owner_plus1;
          w_state_next  = IDLE;
        end
      end

      default: begin
        w_busy_next  = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_done       <= '0;
      r_alu_select <= 1'b0;
      r_busy       <= 1'b0;
      r_owner_id   <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_done       <= w_done_next;
      r_alu_select <= w_alu_select_next;
      r_busy       <= w_busy_next;
      r_owner_id   <= w_owner_id_next;
      r_rr_ptr     <= w_rr_ptr_next;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.done        = r_done;
  assign bus.alu_select  = r_alu_select;
  assign bus.busy        = r_busy;
  assign bus.owner_id    = r_owner_id;
  assign bus.err_timeout = w_err_timeout;

endmodule
